// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline register of the Vespa core.
// Latches the ALU result, store data, destination and memory/writeback controls.
// Resolves conditional branches from the ALU's registered flags.
// Drives the EX->EX forwarding path and counts retiring instructions.
module ex_mem_latch #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Stall,
    input  logic                  i_Flush,
    input  logic                  i_Valid,
    input  logic [WIDTH-1:0]      i_ALU_rslt,
    input  logic [3:0]            i_CCodes,
    input  logic [WIDTH-1:0]      i_StoreData,
    input  logic [REG_ADDR_W-1:0] i_Rd,
    input  logic                  i_RegWE,
    input  logic                  i_MemRE,
    input  logic                  i_MemWE,
    input  logic                  i_IsBranch,
    input  logic [3:0]            i_BrCond,
    input  logic [WIDTH-1:0]      i_BrTarget,
    output logic [WIDTH-1:0]      o_ALU_rslt,
    output logic [WIDTH-1:0]      o_StoreData,
    output logic [REG_ADDR_W-1:0] o_Rd,
    output logic                  o_RegWE,
    output logic                  o_MemRE,
    output logic                  o_MemWE,
    output logic                  o_Valid,
    output logic                  o_BrTaken,
    output logic [WIDTH-1:0]      o_BrTarget,
    output logic                  o_Fwd_Valid,
    output logic [REG_ADDR_W-1:0] o_Fwd_Rd,
    output logic [WIDTH-1:0]      o_Fwd_Data,
    output logic [31:0]           o_InstCnt
);

    // Branch condition evaluation; flags are {V, C, N, Z} from bit 3 down to bit 0.
    function automatic logic br_cond(input logic [3:0] cond, input logic [3:0] cc);
        logic z, n, c, v;
        logic res;
        z = cc[0];
        n = cc[1];
        c = cc[2];
        v = cc[3];
        case (cond)
            4'h0:    res = 1'b0;
            4'h1:    res = 1'b1;
            4'h2:    res = z;
            4'h3:    res = ~z;
            4'h4:    res = c;
            4'h5:    res = ~c;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = n;
            4'h9:    res = ~n;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0]      alu_p1;
    logic [WIDTH-1:0]      store_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic                  regwe_p1;
    logic                  memre_p1;
    logic                  memwe_p1;
    logic                  vld_p1;
    logic                  br_taken_p1;
    logic [WIDTH-1:0]      target_p1;
    logic [31:0]           inst_cnt_p1;

    // Counter base kept as a named net so the increment path is easy to observe.
    logic [31:0]           cnt_base;
    logic [31:0]           cnt_next;

    assign cnt_base = inst_cnt_p1;
    assign cnt_next = cnt_base + {31'b0, i_Valid};

    // ---- EX -> MEM stage boundary ----
    // Register update with priority reset > flush > stall > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_p1      <= '0;
            store_p1    <= '0;
            rd_p1       <= '0;
            regwe_p1    <= 1'b0;
            memre_p1    <= 1'b0;
            memwe_p1    <= 1'b0;
            vld_p1      <= 1'b0;
            br_taken_p1 <= 1'b0;
            target_p1   <= '0;
            inst_cnt_p1 <= '0;
        end else if (i_Flush) begin
            // Bubble: clear controls and data; the retire count is untouched.
            alu_p1      <= '0;
            store_p1    <= '0;
            rd_p1       <= '0;
            regwe_p1    <= 1'b0;
            memre_p1    <= 1'b0;
            memwe_p1    <= 1'b0;
            vld_p1      <= 1'b0;
            br_taken_p1 <= 1'b0;
            target_p1   <= '0;
        end else if (!i_Stall) begin
            alu_p1      <= i_ALU_rslt;
            store_p1    <= i_StoreData;
            rd_p1       <= i_Rd;
            regwe_p1    <= i_RegWE & i_Valid;
            memre_p1    <= i_MemRE & i_Valid;
            memwe_p1    <= i_MemWE & i_Valid;
            vld_p1      <= i_Valid;
            br_taken_p1 <= i_Valid & i_IsBranch & br_cond(i_BrCond, i_CCodes);
            target_p1   <= i_BrTarget;
            inst_cnt_p1 <= cnt_next;
        end
    end

    assign o_ALU_rslt  = alu_p1;
    assign o_StoreData = store_p1;
    assign o_Rd        = rd_p1;
    assign o_RegWE     = regwe_p1;
    assign o_MemRE     = memre_p1;
    assign o_MemWE     = memwe_p1;
    assign o_Valid     = vld_p1;
    assign o_BrTaken   = br_taken_p1;
    assign o_BrTarget  = target_p1;
    assign o_InstCnt   = inst_cnt_p1;

    // Loads are excluded from forwarding; their data only exists after MEM.
    assign o_Fwd_Valid = vld_p1 & regwe_p1 & ~memre_p1;
    assign o_Fwd_Rd    = rd_p1;
    assign o_Fwd_Data  = alu_p1;

endmodule
